// File: rtl/game_status_ctrl_pkg.sv
// Shared definitions for the game status controller and the LCD stage:
// state encodings, display widths and the line-clear score table.
package game_status_ctrl_pkg;

  localparam int TIME_W  = 7;
  localparam int POINT_W = 7;
  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    GS_START  = 2'd0,
    GS_GAMING = 2'd1,
    GS_OVER   = 2'd2
  } game_state_t;

  function automatic logic [3:0] line_score(input logic [2:0] lines);
    logic [3:0] pts;
    case (lines)
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      3'd4:    pts = 4'd8;
      default: pts = 4'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/game_status_ctrl_sec_tick_gen.sv
// Game-second divider: counts 0..CLK_HZ-1 while enabled and raises a
// registered sec_tick during the cycle the count sits at CLK_HZ-1.
module sec_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic Clk,
  input  logic rst,
  input  logic enable,
  output logic sec_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Disabled means the count parks at zero, so every entry starts a fresh second.
  always_comb begin
    cnt_nxt = '0;
    if (enable) begin
      cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sec_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      sec_tick <= enable && (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/game_status_ctrl.sv
// Game status controller: start/gaming/gameOver sequencing, countdown
// timer and saturating line-clear score, all outputs registered.
module game_status_ctrl
  import game_status_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int GAME_TIME = 30,
  parameter int POINT_MAX = 99
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic               start_key,
  input  logic               clear_valid,
  input  logic [2:0]         clear_lines,
  input  logic               top_out,
  output logic [1:0]         gameState,
  output logic [TIME_W-1:0]  timeNum,
  output logic [POINT_W-1:0] point,
  output logic               sec_tick
);

  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_TIME);
  localparam logic [SCORE_W-1:0] POINT_CAP = SCORE_W'(POINT_MAX);

  function automatic logic [POINT_W-1:0] sat_add(input logic [POINT_W-1:0] base,
                                                  input logic [3:0]         add);
    logic [SCORE_W-1:0] sum;
    sum = SCORE_W'(base) + SCORE_W'(add);
    if (sum > POINT_CAP) sum = POINT_CAP;
    return sum[POINT_W-1:0];
  endfunction

  game_state_t        state_q, state_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [POINT_W-1:0] point_q, point_d;
  logic               start_q;
  logic               start_edge;
  logic               run_en;

  assign start_edge = start_key & ~start_q;

  // The divider runs only while gaming continues across the edge, so it
  // reads zero on entry and is cleared on the edge that leaves gaming.
  assign run_en = (state_q == GS_GAMING) && (state_d == GS_GAMING);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .Clk      (Clk),
    .rst      (rst),
    .enable   (run_en),
    .sec_tick (sec_tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    point_d = point_q;
    case (state_q)
      GS_START: begin
        if (start_edge) begin
          state_d = GS_GAMING;
          time_d  = TIME_INIT;
          point_d = '0;
        end
      end
      GS_GAMING: begin
        if (clear_valid) point_d = sat_add(point_q, line_score(clear_lines));
        // top_out freezes the clock even if a tick lands on the same cycle
        if (top_out) begin
          state_d = GS_OVER;
        end else if (sec_tick) begin
          time_d = time_q - TIME_W'(1);
          if (time_q == TIME_W'(1)) state_d = GS_OVER;
        end
      end
      GS_OVER: begin
        if (start_edge) state_d = GS_START;
      end
      default: state_d = GS_START;
    endcase
  end

  // Start key history resets high so a key held through reset is not a press.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= GS_START;
      time_q  <= TIME_INIT;
      point_q <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      point_q <= point_d;
      start_q <= start_key;
    end
  end

  assign gameState = state_q;
  assign timeNum   = time_q;
  assign point     = point_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Bench for game_status_ctrl: behavioural game model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_game_status_ctrl;

  localparam int CLK_HZ = 10;
  localparam int GT     = 3;
  localparam int PMAX   = 99;

  logic       Clk = 1'b0;
  logic       rst;
  logic       start_key;
  logic       clear_valid;
  logic [2:0] clear_lines;
  logic       top_out;
  logic [1:0] gameState;
  logic [6:0] timeNum;
  logic [6:0] point;
  logic       sec_tick;

  int n_cmp  = 0;
  int n_fail = 0;
  int tick_cnt = 0;

  game_status_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .GAME_TIME (GT),
    .POINT_MAX (PMAX)
  ) dut (
    .Clk         (Clk),
    .rst         (rst),
    .start_key   (start_key),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .top_out     (top_out),
    .gameState   (gameState),
    .timeNum     (timeNum),
    .point       (point),
    .sec_tick    (sec_tick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State numbers: 0 start, 1 playing, 2 over. elapsed = cycles since the game began.
  int m_state, m_time, m_point, m_elapsed;
  bit m_prev, m_valid;
  int score_tab [8] = '{0, 1, 3, 5, 8, 0, 0, 0};

  function automatic bit m_tick();
    return (m_state == 1) && ((m_elapsed % CLK_HZ) == CLK_HZ - 1);
  endfunction

  always @(posedge Clk) begin
    bit st_edge;
    bit tk;
    st_edge = start_key && !m_prev;
    tk      = m_tick();
    if (rst) begin
      m_state = 0; m_time = GT; m_point = 0; m_elapsed = 0;
      m_valid = 1'b1;
    end else begin
      if (m_state == 0) begin
        if (st_edge) begin
          m_state = 1; m_time = GT; m_point = 0; m_elapsed = 0;
        end
      end else if (m_state == 1) begin
        if (clear_valid) begin
          m_point = m_point + score_tab[clear_lines];
          if (m_point > PMAX) m_point = PMAX;
        end
        if (top_out) m_state = 2;
        else if (tk) begin
          m_time = m_time - 1;
          if (m_time == 0) m_state = 2;
        end
        m_elapsed++;
      end else begin
        if (st_edge) m_state = 0;
      end
    end
    m_prev = rst ? 1'b1 : start_key;
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("model_state", int'(gameState), m_state);
      chk("model_time",  int'(timeNum),   m_time);
      chk("model_point", int'(point),     m_point);
      chk("model_tick",  int'(sec_tick),  int'(m_tick()));
    end
    if (sec_tick === 1'b1) tick_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic press();
    start_key = 1'b1;
    @(negedge Clk);
    start_key = 1'b0;
    @(negedge Clk);
  endtask

  task automatic clear(input int n);
    clear_valid = 1'b1;
    clear_lines = 3'(n);
    @(negedge Clk);
    clear_valid = 1'b0;
    clear_lines = 3'd0;
  endtask

  initial begin
    bit done;
    rst = 1'b1; start_key = 1'b0; clear_valid = 1'b0; clear_lines = 3'd0; top_out = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_state", gameState, 0);
    chk("rst_time",  timeNum,   3);
    chk("rst_point", point,     0);
    chk("rst_tick",  sec_tick,  0);
    rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("idle_start_state", gameState, 0);

    // Full countdown with no activity
    tick_cnt = 0;
    press();
    chk("go_state", gameState, 1);
    chk("go_time",  timeNum,   3);
    chk("go_point", point,     0);
    repeat (9) @(negedge Clk);
    chk("t10_time", timeNum, 2);
    repeat (10) @(negedge Clk);
    chk("t20_time", timeNum, 1);
    repeat (9) @(negedge Clk);
    chk("t29_state", gameState, 1);
    chk("t29_tick",  sec_tick,  1);
    @(negedge Clk);
    chk("t30_state", gameState, 2);
    chk("t30_time",  timeNum,   0);
    chk("tick_count", tick_cnt, 3);
    repeat (3) @(negedge Clk);
    chk("over_tick_quiet", sec_tick, 0);

    // Scoring and saturation
    press();
    chk("restart_to_start", gameState, 0);
    press();
    chk("regame_state", gameState, 1);
    chk("regame_time",  timeNum,   3);
    clear(4); chk("score_4", point, 8);
    clear(3); chk("score_3", point, 13);
    clear(1); chk("score_1", point, 14);
    clear(0); chk("score_0", point, 14);
    clear(6); chk("score_6", point, 14);
    repeat (12) clear(4);
    chk("score_sat", point, 99);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      if (gameState == 2'd2) done = 1'b1;
    end
    chk("timeout_wait_over", int'(done), 1);
    chk("sat_hold", point, 99);

    // top_out freezes the timer; later clears ignored
    press();
    press();
    repeat (9) @(negedge Clk);
    chk("pre_top_time", timeNum, 2);
    top_out = 1'b1;
    @(negedge Clk);
    top_out = 1'b0;
    chk("top_state", gameState, 2);
    chk("top_time",  timeNum,   2);
    clear(4);
    chk("over_clear_ignored", point, 0);
    repeat (12) @(negedge Clk);
    chk("top_time_hold",  timeNum,   2);
    chk("top_state_hold", gameState, 2);

    // Clear coinciding with the final tick
    press();
    press();
    clear(3);
    chk("final_pre_point", point, 5);
    repeat (27) @(negedge Clk);
    chk("final_tick_cycle", sec_tick, 1);
    chk("final_tick_time",  timeNum,  1);
    clear(2);
    chk("final_point", point,     8);
    chk("final_state", gameState, 2);
    chk("final_time",  timeNum,   0);

    // Key held through reset, then mid-game reset
    rst = 1'b1; start_key = 1'b1;
    repeat (3) @(negedge Clk);
    rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("held_key_no_start", gameState, 0);
    start_key = 1'b0;
    @(negedge Clk);
    press();
    chk("repress_state", gameState, 1);
    clear(4);
    chk("mid_point", point, 8);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0;
    chk("midrst_state", gameState, 0);
    chk("midrst_time",  timeNum,   3);
    chk("midrst_point", point,     0);
    repeat (2) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
